// File: rtl/song_sequencer.sv
// song_sequencer: plays an event table (keycodes + duration) onto the tone generator's song input.
// Optional build macro SONG_GAP_EN inserts one silent tick between events so repeated notes retrigger.
module song_sequencer #(
  parameter int DEPTH    = 64,
  parameter int AW       = 6,
  parameter int PRESCALE = 50000
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic [AW-1:0] mem_address,
  input  logic          mem_write,
  input  logic [31:0]   mem_writedata,
  output logic [31:0]   mem_readdata,
  input  logic          ctrl_write,
  input  logic [31:0]   ctrl_writedata,
  output logic [31:0]   status,
  output logic [31:0]   song,
  output logic          song_done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_PLAY  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  logic [31:0]   r_table [DEPTH];
  state_t        r_state;
  state_t        w_state_nxt;
  logic [AW:0]   r_idx;
  logic [AW:0]   w_idx_nxt;
  logic [31:0]   r_song;
  logic [31:0]   w_song_nxt;
  logic [7:0]    r_dur;
  logic [7:0]    w_dur_nxt;
  logic          r_done;
  logic          w_done_nxt;
  logic          r_loop;
  logic [15:0]   r_tick_div;
  logic [PW-1:0] r_pre;
  logic [15:0]   r_div;
  logic          w_pre_clr;
  logic          w_pre_wrap;
  logic          w_tick;
  logic          w_start;
  logic          w_stop;
  logic [31:0]   w_entry;
  logic          w_end;
  logic          w_unused;

  assign w_start  = ctrl_write & ctrl_writedata[0];
  assign w_stop   = ctrl_write & ctrl_writedata[1];
  assign w_unused = &{1'b0, ctrl_writedata[15:3]};

  // Table: one host write port, one host read port, one internal read port.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++) r_table[i] <= '0;
    end else if (mem_write) begin
      r_table[mem_address] <= mem_writedata;
    end
  end

  assign mem_readdata = r_table[mem_address];
  assign w_entry      = r_table[r_idx[AW-1:0]];
  // The extra index bit marks a step past the last entry, handled like an end marker.
  assign w_end        = (w_entry[31:24] == 8'd0) || r_idx[AW];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_loop     <= 1'b0;
      r_tick_div <= '0;
    end else if (ctrl_write) begin
      r_loop     <= ctrl_writedata[2];
      r_tick_div <= ctrl_writedata[31:16];
    end
  end

  assign w_pre_wrap = (r_pre == PW'(PRESCALE - 1));
  assign w_tick     = w_pre_wrap && (r_div >= r_tick_div);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_pre <= '0;
      r_div <= '0;
    end else if (w_pre_clr) begin
      r_pre <= '0;
      r_div <= '0;
    end else if (w_pre_wrap) begin
      r_pre <= '0;
      r_div <= w_tick ? 16'd0 : r_div + 16'd1;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_song_nxt  = r_song;
    w_dur_nxt   = r_dur;
    w_done_nxt  = 1'b0;
    w_pre_clr   = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (!w_end) begin
          w_song_nxt  = {8'h00, w_entry[23:0]};
          w_dur_nxt   = w_entry[31:24];
          w_pre_clr   = 1'b1;
          w_state_nxt = S_PLAY;
        end else if (r_loop && (r_idx != '0)) begin
          w_idx_nxt = '0;
        end else begin
          w_song_nxt  = '0;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_PLAY: begin
        if (w_tick) begin
          if (r_dur == 8'd1) begin
`ifdef SONG_GAP_EN
            w_song_nxt  = '0;
            w_pre_clr   = 1'b1;
            w_state_nxt = S_GAP;
`else
            w_idx_nxt   = r_idx + 1'b1;
            w_state_nxt = S_FETCH;
`endif
          end else begin
            w_dur_nxt = r_dur - 8'd1;
          end
        end
      end
`ifdef SONG_GAP_EN
      S_GAP: begin
        if (w_tick) begin
          w_idx_nxt   = r_idx + 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
`endif
      default: begin
        w_song_nxt = '0;
      end
    endcase
    // Stop overrides start; both override whatever the current state wanted.
    if (w_stop) begin
      w_state_nxt = S_IDLE;
      w_song_nxt  = '0;
      w_done_nxt  = 1'b0;
    end else if (w_start) begin
      w_state_nxt = S_FETCH;
      w_idx_nxt   = '0;
      w_done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_idx  <= '0;
      r_song <= '0;
      r_dur  <= '0;
      r_done <= 1'b0;
    end else begin
      r_idx  <= w_idx_nxt;
      r_song <= w_song_nxt;
      r_dur  <= w_dur_nxt;
      r_done <= w_done_nxt;
    end
  end

  always_comb begin
    status            = '0;
    status[0]         = (r_state != S_IDLE);
    status[1]         = r_loop;
    status[AW+7:8]    = r_idx[AW-1:0];
  end

  assign song      = r_song;
  assign song_done = r_done;

endmodule
